// File: rtl/video_timing_pkg.sv
// Timing constants, recovery FSM state type and frame-counter helper shared by the
// video timing generator and the receive-side signal recovery block.
package video_timing_pkg;

   localparam int H_ACTIVE_720P   = 1280;
   localparam int H_FP_720P       = 110;
   localparam int H_SYNC_720P     = 40;
   localparam int H_BP_720P       = 220;
   localparam int V_ACTIVE_720P   = 720;
   localparam int V_FP_720P       = 5;
   localparam int V_SYNC_720P     = 5;
   localparam int V_BP_720P       = 20;
   localparam int LOCK_FRAMES_DEF = 2;

   localparam logic [5:0] FC_WRAP = 6'd59;

   typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} recover_state_t;

   // Frame counter runs 0..FC_WRAP and wraps back to 0.
   function automatic logic [5:0] fc_inc(input logic [5:0] fc);
      return (fc == FC_WRAP) ? 6'd0 : fc + 6'd1;
   endfunction

endpackage

// File: rtl/sig_edge_det.sv
// One-bit edge detector: keeps a registered copy of the input and flags
// rising/falling edges against it.
module sig_edge_det (
   input  logic clk,
   input  logic srst,
   input  logic sig,
   output logic rise,
   output logic fall,
   output logic dly
);

   logic dly_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         dly_reg <= 1'b0;
      end else begin
         dly_reg <= sig;
      end
   end

   assign rise = sig & ~dly_reg;
   assign fall = ~sig & dly_reg;
   assign dly  = dly_reg;

endmodule

// File: rtl/video_sig_recover.sv
// Recovers pixel coordinates, frame pulses and a frame counter from incoming hs/vs/ad
// strobes, and checks timing for lock. Optional VIDEO_SIG_RECOVER_MEAS_OUT_EN exposes measurements.
module video_sig_recover
   import video_timing_pkg::*;
#(
   parameter int ACTIVE_H_PIXELS = H_ACTIVE_720P,
   parameter int H_FRONT_PORCH   = H_FP_720P,
   parameter int H_SYNC_WIDTH    = H_SYNC_720P,
   parameter int H_BACK_PORCH    = H_BP_720P,
   parameter int ACTIVE_LINES    = V_ACTIVE_720P,
   parameter int V_FRONT_PORCH   = V_FP_720P,
   parameter int V_SYNC_WIDTH    = V_SYNC_720P,
   parameter int V_BACK_PORCH    = V_BP_720P,
   parameter int LOCK_FRAMES     = LOCK_FRAMES_DEF,
   localparam int TOTAL_PIXELS   = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH,
   localparam int TOTAL_LINES    = ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH,
   localparam int HC_W           = $clog2(TOTAL_PIXELS),
   localparam int VC_W           = $clog2(TOTAL_LINES),
   localparam int MH_W           = $clog2(2 * TOTAL_PIXELS),
   localparam int LN_W           = $clog2(TOTAL_LINES) + 1
) (
   input  logic            clk_pixel_in,
   input  logic            rst_in,
   input  logic            hs_in,
   input  logic            vs_in,
   input  logic            ad_in,
   output logic [HC_W-1:0] hcount_out,
   output logic [VC_W-1:0] vcount_out,
   output logic            ad_out,
   output logic            nf_out,
   output logic [5:0]      fc_out,
   output logic            locked_out,
   output logic            err_out
`ifdef VIDEO_SIG_RECOVER_MEAS_OUT_EN
   ,
   output logic [MH_W-1:0] meas_htotal_out,
   output logic [LN_W-1:0] meas_vtotal_out,
   output logic [LN_W-1:0] meas_vactive_out
`endif
);

   localparam int LC_W = MH_W + 1;
   localparam int GC_W = $clog2(LOCK_FRAMES + 1);

   logic [2:0] sig_vec, rise_vec, fall_vec, dly_vec;
   logic       hs_rise, vs_rise, ad_rise, ad_fall;
   logic       unused_edges;

   assign sig_vec = {ad_in, vs_in, hs_in};

   for (genvar gi = 0; gi < 3; gi++) begin : g_edge
      sig_edge_det u_edge (
         .clk  (clk_pixel_in),
         .srst (rst_in),
         .sig  (sig_vec[gi]),
         .rise (rise_vec[gi]),
         .fall (fall_vec[gi]),
         .dly  (dly_vec[gi])
      );
   end

   assign hs_rise      = rise_vec[0];
   assign vs_rise      = rise_vec[1];
   assign ad_rise      = rise_vec[2];
   assign ad_fall      = fall_vec[2];
   assign unused_edges = ^{fall_vec[1:0], dly_vec[1:0]};

   recover_state_t  state_reg, state_next;
   logic [GC_W-1:0] good_cnt_reg, good_cnt_next;
   logic            err_next;
   logic [LC_W-1:0] line_cyc_reg, act_pix_reg;
   logic [LN_W-1:0] act_lines_reg, tot_lines_reg, act_lines_end, tot_lines_end;
   logic            frame_bad_reg, line_bad, frame_fail, timeout;
   logic [HC_W-1:0] hcount_reg;
   logic [VC_W-1:0] vcount_reg;
   logic [5:0]      fc_reg;
   logic            nf_reg, locked_reg, err_reg;

   // Events coinciding with the vs rise are folded into the frame that is ending.
   always_comb begin
      line_bad      = (line_cyc_reg != LC_W'(TOTAL_PIXELS)) ||
                      ((act_pix_reg != '0) && (act_pix_reg != LC_W'(ACTIVE_H_PIXELS)));
      tot_lines_end = tot_lines_reg + LN_W'(hs_rise);
      act_lines_end = act_lines_reg + LN_W'(ad_fall);
      frame_fail    = frame_bad_reg || (hs_rise && line_bad) ||
                      (act_lines_end != LN_W'(ACTIVE_LINES)) ||
                      (tot_lines_end != LN_W'(TOTAL_LINES));
      timeout       = (line_cyc_reg == LC_W'(2 * TOTAL_PIXELS)) && !hs_rise;
   end

   always_comb begin
      state_next    = state_reg;
      good_cnt_next = good_cnt_reg;
      err_next      = 1'b0;
      if (timeout) begin
         state_next    = SEARCH;
         good_cnt_next = '0;
         err_next      = (state_reg == LOCKED);
      end else if (vs_rise) begin
         case (state_reg)
            SEARCH: state_next = MEASURE;
            MEASURE: begin
               if (frame_fail) begin
                  good_cnt_next = '0;
               end else if (good_cnt_reg == GC_W'(LOCK_FRAMES - 1)) begin
                  state_next    = LOCKED;
                  good_cnt_next = '0;
               end else begin
                  good_cnt_next = good_cnt_reg + 1'b1;
               end
            end
            LOCKED: begin
               if (frame_fail) begin
                  state_next    = MEASURE;
                  good_cnt_next = '0;
                  err_next      = 1'b1;
               end
            end
            default: state_next = SEARCH;
         endcase
      end
   end

   always_ff @(posedge clk_pixel_in) begin
      if (rst_in) begin
         state_reg     <= SEARCH;
         good_cnt_reg  <= '0;
         line_cyc_reg  <= '0;
         act_pix_reg   <= '0;
         act_lines_reg <= '0;
         tot_lines_reg <= '0;
         frame_bad_reg <= 1'b0;
         hcount_reg    <= '0;
         vcount_reg    <= '0;
         fc_reg        <= '0;
         nf_reg        <= 1'b0;
         locked_reg    <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         state_reg    <= state_next;
         good_cnt_reg <= good_cnt_next;
         locked_reg   <= (state_next == LOCKED);
         err_reg      <= err_next;
         nf_reg       <= vs_rise && (state_reg != SEARCH);
         if (vs_rise && (state_reg != SEARCH)) begin
            fc_reg <= fc_inc(fc_reg);
         end

         if (ad_rise) begin
            hcount_reg <= '0;
         end else if (ad_in && (hcount_reg != '1)) begin
            hcount_reg <= hcount_reg + 1'b1;
         end

         if (vs_rise) begin
            vcount_reg <= '0;
         end else if (ad_fall && (vcount_reg != VC_W'(TOTAL_LINES - 1))) begin
            vcount_reg <= vcount_reg + 1'b1;
         end

         // The hs rise cycle is the first cycle of the new line.
         if (hs_rise) begin
            line_cyc_reg <= LC_W'(1);
            act_pix_reg  <= LC_W'(ad_in);
         end else begin
            line_cyc_reg <= timeout ? '0 : line_cyc_reg + 1'b1;
            if (ad_in && (act_pix_reg != '1)) begin
               act_pix_reg <= act_pix_reg + 1'b1;
            end
         end

         if (vs_rise) begin
            frame_bad_reg <= 1'b0;
            tot_lines_reg <= '0;
            act_lines_reg <= '0;
         end else begin
            if (hs_rise && line_bad) begin
               frame_bad_reg <= 1'b1;
            end
            if (hs_rise && (tot_lines_reg != '1)) begin
               tot_lines_reg <= tot_lines_reg + 1'b1;
            end
            if (ad_fall && (act_lines_reg != '1)) begin
               act_lines_reg <= act_lines_reg + 1'b1;
            end
         end
      end
   end

`ifdef VIDEO_SIG_RECOVER_MEAS_OUT_EN
   logic [MH_W-1:0] meas_htotal_reg;
   logic [LN_W-1:0] meas_vtotal_reg, meas_vactive_reg;

   always_ff @(posedge clk_pixel_in) begin
      if (rst_in) begin
         meas_htotal_reg  <= '0;
         meas_vtotal_reg  <= '0;
         meas_vactive_reg <= '0;
      end else begin
         if (hs_rise) begin
            meas_htotal_reg <= line_cyc_reg[MH_W-1:0];
         end
         if (vs_rise) begin
            meas_vtotal_reg  <= tot_lines_end;
            meas_vactive_reg <= act_lines_end;
         end
      end
   end

   assign meas_htotal_out  = meas_htotal_reg;
   assign meas_vtotal_out  = meas_vtotal_reg;
   assign meas_vactive_out = meas_vactive_reg;
`endif

   assign hcount_out = hcount_reg;
   assign vcount_out = vcount_reg;
   assign ad_out     = dly_vec[2];
   assign nf_out     = nf_reg;
   assign fc_out     = fc_reg;
   assign locked_out = locked_reg;
   assign err_out    = err_reg;

endmodule
